// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcodes, function codes, FSM states, decoded-instruction
// enumeration and immediate helpers for the multicycle RV32 core.
// Optional feature macro: RISCV_MC_MUL_EN (enables decode of mul).
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLT = 3'b010;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BLT = 3'b100;
   localparam logic [2:0] F3_BGE = 3'b101;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;
   localparam logic [6:0] F7_MUL  = 7'b0000001;

   localparam logic [31:0] EOF_WORD = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
   } state_t;

   typedef enum logic [4:0] {
      I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SLT, I_MUL, I_ADDI,
      I_LW, I_SW, I_BEQ, I_BNE, I_BLT, I_BGE, I_JAL, I_LUI, I_ILL
   } instr_t;

   function automatic logic [31:0] imm_i(input logic [31:0] ir);
      return {{20{ir[31]}}, ir[31:20]};
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] ir);
      return {{20{ir[31]}}, ir[31:25], ir[11:7]};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] ir);
      return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] ir);
      return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
   endfunction

   function automatic logic [31:0] imm_u(input logic [31:0] ir);
      return {ir[31:12], 12'b0};
   endfunction

   // Map an instruction word onto the supported subset; anything else is I_ILL.
   function automatic instr_t decode(input logic [31:0] ir);
      instr_t d;
      d = I_ILL;
      case (ir[6:0])
         OP_R: begin
            case ({ir[31:25], ir[14:12]})
               {F7_BASE, F3_ADD}: d = I_ADD;
               {F7_SUB,  F3_ADD}: d = I_SUB;
               {F7_BASE, F3_AND}: d = I_AND;
               {F7_BASE, F3_OR }: d = I_OR;
               {F7_BASE, F3_XOR}: d = I_XOR;
               {F7_BASE, F3_SLT}: d = I_SLT;
`ifdef RISCV_MC_MUL_EN
               {F7_MUL,  F3_ADD}: d = I_MUL;
`endif
               default:           d = I_ILL;
            endcase
         end
         OP_IALU:   d = (ir[14:12] == F3_ADD) ? I_ADDI : I_ILL;
         OP_LOAD:   d = (ir[14:12] == F3_LW)  ? I_LW   : I_ILL;
         OP_STORE:  d = (ir[14:12] == F3_SW)  ? I_SW   : I_ILL;
         OP_BRANCH: begin
            case (ir[14:12])
               F3_BEQ:  d = I_BEQ;
               F3_BNE:  d = I_BNE;
               F3_BLT:  d = I_BLT;
               F3_BGE:  d = I_BGE;
               default: d = I_ILL;
            endcase
         end
         OP_JAL:    d = I_JAL;
         OP_LUI:    d = I_LUI;
         default:   d = I_ILL;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/riscv_regfile.sv
// riscv_regfile: 32x32 integer register file, two asynchronous read ports,
// one synchronous write port, x0 hardwired to zero, cleared on reset.
module riscv_regfile (
   input  logic        clk,
   input  logic        rstn,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2,
   input  logic        wen,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata
);

   logic [31:0] regs [0:31];

   // Synchronous clear on reset, otherwise write rd unless it is x0.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wen && (waddr != 5'd0)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
   assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/riscv_mc_core.sv
// riscv_mc_core: multicycle RV32 integer core with variable-latency
// req/valid instruction and data ports, EOF/illegal halt and counters.
// Optional feature macro: RISCV_MC_MUL_EN (mul in EX).
import riscv_pkg::*;

module riscv_mc_core #(
   parameter int          ADDR_W   = 10,
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic              CLOCK_50,
   input  logic              rstn,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_valid,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_valid,
   output logic              done,
   output logic              illegal,
   output logic [CNT_W-1:0]  clock_count,
   output logic [CNT_W-1:0]  instr_cnt
);

   state_t      state;
   instr_t      op;
   instr_t      dec;
   logic [31:0] pc, ir, a, b, alu_out, mdr;
   logic [31:0] rs1_data, rs2_data;
   logic [31:0] alu_res, pc_plus4;
   logic        taken, halt_now;
   logic        rf_we;
   logic [31:0] rf_wd;

   assign dec       = decode(ir);
   assign pc_plus4  = pc + 32'd4;
   assign imem_addr = pc[ADDR_W+1:2];
   assign halt_now  = (state == S_ID) && ((ir == EOF_WORD) || (dec == I_ILL));

   // jal links in EX; every other register write happens in WB.
   assign rf_we = ((state == S_EX) && (op == I_JAL)) || (state == S_WB);
   assign rf_wd = (state == S_EX) ? pc_plus4 : ((op == I_LW) ? mdr : alu_out);

   riscv_regfile u_regfile (
      .clk    (CLOCK_50),
      .rstn   (rstn),
      .raddr1 (ir[19:15]),
      .raddr2 (ir[24:20]),
      .rdata1 (rs1_data),
      .rdata2 (rs2_data),
      .wen    (rf_we),
      .waddr  (ir[11:7]),
      .wdata  (rf_wd)
   );

   // EX-stage datapath: arithmetic result and branch condition.
   always_comb begin
      alu_res = '0;
      taken   = 1'b0;
      case (op)
         I_ADD:  alu_res = a + b;
         I_SUB:  alu_res = a - b;
         I_AND:  alu_res = a & b;
         I_OR:   alu_res = a | b;
         I_XOR:  alu_res = a ^ b;
         I_SLT:  alu_res = {31'b0, $signed(a) < $signed(b)};
`ifdef RISCV_MC_MUL_EN
         I_MUL:  alu_res = a * b;
`endif
         I_ADDI: alu_res = a + imm_i(ir);
         I_LW:   alu_res = a + imm_i(ir);
         I_SW:   alu_res = a + imm_s(ir);
         I_LUI:  alu_res = imm_u(ir);
         I_BEQ:  taken = (a == b);
         I_BNE:  taken = (a != b);
         I_BLT:  taken = ($signed(a) <  $signed(b));
         I_BGE:  taken = ($signed(a) >= $signed(b));
         default: alu_res = '0;
      endcase
   end

   // Control FSM with registered memory requests, status flags and counters.
   always_ff @(posedge CLOCK_50) begin
      if (!rstn) begin
         state       <= S_IDLE;
         pc          <= PC_RESET;
         ir          <= '0;
         mdr         <= '0;
         alu_out     <= '0;
         a           <= '0;
         b           <= '0;
         op          <= I_ILL;
         done        <= 1'b0;
         illegal     <= 1'b0;
         clock_count <= '0;
         instr_cnt   <= '0;
         imem_req    <= 1'b0;
         dmem_req    <= 1'b0;
         dmem_we     <= 1'b0;
         dmem_addr   <= '0;
         dmem_wdata  <= '0;
      end else begin
         if (!done && !halt_now && (clock_count != '1))
            clock_count <= clock_count + 1'b1;
         case (state)
            S_IDLE: begin
               imem_req <= 1'b1;
               state    <= S_IF;
            end
            S_IF: begin
               if (imem_valid) begin
                  ir       <= imem_rdata;
                  imem_req <= 1'b0;
                  state    <= S_ID;
               end
            end
            S_ID: begin
               a       <= rs1_data;
               b       <= rs2_data;
               op      <= dec;
               alu_out <= pc + ((ir[6:0] == OP_JAL) ? imm_j(ir) : imm_b(ir));
               if (ir == EOF_WORD) begin
                  done  <= 1'b1;
                  state <= S_HALT;
               end else if (dec == I_ILL) begin
                  done    <= 1'b1;
                  illegal <= 1'b1;
                  state   <= S_HALT;
               end else begin
                  state <= S_EX;
               end
            end
            S_EX: begin
               case (op)
                  I_BEQ, I_BNE, I_BLT, I_BGE, I_JAL: begin
                     pc        <= (taken || (op == I_JAL)) ? alu_out : pc_plus4;
                     instr_cnt <= instr_cnt + 1'b1;
                     imem_req  <= 1'b1;
                     state     <= S_IF;
                  end
                  I_LW, I_SW: begin
                     alu_out    <= alu_res;
                     dmem_req   <= 1'b1;
                     dmem_we    <= (op == I_SW);
                     dmem_addr  <= alu_res[ADDR_W+1:2];
                     dmem_wdata <= b;
                     state      <= S_MEM;
                  end
                  default: begin
                     alu_out <= alu_res;
                     state   <= S_WB;
                  end
               endcase
            end
            S_MEM: begin
               if (dmem_valid) begin
                  dmem_req <= 1'b0;
                  if (dmem_we) begin
                     pc        <= pc_plus4;
                     instr_cnt <= instr_cnt + 1'b1;
                     imem_req  <= 1'b1;
                     state     <= S_IF;
                  end else begin
                     mdr   <= dmem_rdata;
                     state <= S_WB;
                  end
               end
            end
            S_WB: begin
               pc        <= pc_plus4;
               instr_cnt <= instr_cnt + 1'b1;
               imem_req  <= 1'b1;
               state     <= S_IF;
            end
            S_HALT: state <= S_HALT;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_mc_core.sv
// tb_riscv_mc_core: directed self-checking bench for riscv_mc_core with
// behavioural instruction/data memories of programmable latency.
// Honours RISCV_MC_MUL_EN for the mul scenario.
module tb_riscv_mc_core;

   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic              imem_valid;
   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [31:0]       dmem_wdata;
   logic [31:0]       dmem_rdata;
   logic              dmem_valid;
   logic              done;
   logic              illegal;
   logic [31:0]       clock_count;
   logic [31:0]       instr_cnt;

   int checks = 0;
   int failures = 0;

   logic [31:0] rom [0:1023];
   logic [31:0] ram [0:1023];
   int ilat = 0;
   int dlat = 0;
   int icnt = 0;
   int dcnt = 0;
   int          st_cnt = 0;
   logic [31:0] st_addr = '0;
   logic [31:0] st_data = '0;

   riscv_mc_core #(.ADDR_W(ADDR_W), .PC_RESET(32'h0000_0000), .CNT_W(32)) dut (
      .CLOCK_50    (clk),
      .rstn        (rstn),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_valid  (imem_valid),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_rdata  (dmem_rdata),
      .dmem_valid  (dmem_valid),
      .done        (done),
      .illegal     (illegal),
      .clock_count (clock_count),
      .instr_cnt   (instr_cnt)
   );

   always #5 clk = ~clk;

   assign imem_rdata = rom[imem_addr];
   assign imem_valid = imem_req && (icnt >= ilat);
   assign dmem_rdata = ram[dmem_addr];
   assign dmem_valid = dmem_req && (dcnt >= dlat);

   // Memory wait-state counters and data-memory write/log.
   always @(posedge clk) begin
      if (!imem_req || imem_valid) icnt <= 0; else icnt <= icnt + 1;
      if (!dmem_req || dmem_valid) dcnt <= 0; else dcnt <= dcnt + 1;
      if (dmem_req && dmem_valid && dmem_we) begin
         ram[dmem_addr] <= dmem_wdata;
         st_cnt  <= st_cnt + 1;
         st_addr <= {22'b0, dmem_addr};
         st_data <= dmem_wdata;
      end
   end

   // ---------------- instruction encoders ----------------
   function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'b0010011};
   endfunction
   function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b010, rd, 7'b0000011};
   endfunction
   function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] br(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] jal(input logic [4:0] rd, input logic [20:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction
   function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
      return {imm, rd, 7'b0110111};
   endfunction

   // ---------------- sequencing helpers ----------------
   task automatic clear_rom();
      for (int i = 0; i < 1024; i++) rom[i] = 32'hFFFF_FFFF;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_done(input int budget, output bit timed_out);
      timed_out = 1'b1;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (done) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      clear_rom();
      ilat = 0; dlat = 0;
      do_reset();
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req got=%b exp=0", imem_req); end
      checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL reset_dmem_req got=%b exp=0", dmem_req); end
      checks++; if (imem_addr !== 10'd0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", imem_addr); end
      checks++; if ({done, illegal} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {done, illegal}); end
      checks++; if (clock_count !== 32'd0 || instr_cnt !== 32'd0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", clock_count, instr_cnt); end
      rstn = 1'b1;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || clock_count !== 32'd1) begin failures++; $display("FAIL first_fetch got req=%b cc=%0d exp req=1 cc=1", imem_req, clock_count); end
   endtask

   task automatic test_basic();
      bit to;
      clear_rom();
      rom[0] = addi(5'd1, 5'd0, 12'd5);
      rom[1] = addi(5'd2, 5'd0, 12'd7);
      rom[2] = r_op(7'b0000000, 3'b000, 5'd3, 5'd1, 5'd2);
      ilat = 0; dlat = 0;
      do_reset(); rstn = 1'b1;
      wait_done(200, to);
      checks++; if (to) begin failures++; $display("FAIL basic_timeout got=no_done exp=done"); end
      checks++; if (dut.u_regfile.regs[3] !== 32'd12) begin failures++; $display("FAIL basic_x3 got=%0d exp=12", dut.u_regfile.regs[3]); end
      checks++; if (instr_cnt !== 32'd3) begin failures++; $display("FAIL basic_instr_cnt got=%0d exp=3", instr_cnt); end
      checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL basic_illegal got=%b exp=0", illegal); end
      checks++; if (clock_count !== 32'd14) begin failures++; $display("FAIL basic_clock_count got=%0d exp=14", clock_count); end
      repeat (5) @(negedge clk);
      checks++; if (clock_count !== 32'd14 || done !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL basic_frozen got cc=%0d done=%b req=%b exp 14/1/0", clock_count, done, imem_req); end
   endtask

   task automatic test_mem_wait();
      bit to;
      int s0;
      clear_rom();
      rom[0] = addi(5'd3, 5'd0, 12'd12);
      rom[1] = sw(5'd3, 5'd0, 12'd8);
      rom[2] = lw(5'd4, 5'd0, 12'd8);
      ilat = 0; dlat = 3;
      do_reset(); rstn = 1'b1;
      s0 = st_cnt;
      wait_done(300, to);
      checks++; if (to) begin failures++; $display("FAIL memwait_timeout got=no_done exp=done"); end
      checks++; if (st_cnt - s0 !== 1 || st_addr !== 32'd2 || st_data !== 32'd12) begin failures++; $display("FAIL memwait_store got n=%0d addr=%0d data=%0d exp 1/2/12", st_cnt - s0, st_addr, st_data); end
      checks++; if (dut.u_regfile.regs[4] !== 32'd12) begin failures++; $display("FAIL memwait_x4 got=%0d exp=12", dut.u_regfile.regs[4]); end
      checks++; if (instr_cnt !== 32'd3) begin failures++; $display("FAIL memwait_instr_cnt got=%0d exp=3", instr_cnt); end
      checks++; if (clock_count !== 32'd21) begin failures++; $display("FAIL memwait_clock_count got=%0d exp=21", clock_count); end
      dlat = 0;
   endtask

   task automatic test_loop();
      bit to;
      clear_rom();
      rom[0] = addi(5'd1, 5'd0, 12'd0);
      rom[1] = addi(5'd2, 5'd0, 12'd4);
      rom[2] = addi(5'd1, 5'd1, 12'd1);
      rom[3] = br(3'b100, 5'd1, 5'd2, 13'h1FFC);
      do_reset(); rstn = 1'b1;
      wait_done(300, to);
      checks++; if (to) begin failures++; $display("FAIL loop_timeout got=no_done exp=done"); end
      checks++; if (dut.u_regfile.regs[1] !== 32'd4) begin failures++; $display("FAIL loop_x1 got=%0d exp=4", dut.u_regfile.regs[1]); end
      checks++; if (instr_cnt !== 32'd10) begin failures++; $display("FAIL loop_instr_cnt got=%0d exp=10", instr_cnt); end
      checks++; if (clock_count !== 32'd38) begin failures++; $display("FAIL loop_clock_count got=%0d exp=38", clock_count); end
   endtask

   task automatic test_alu_ops();
      bit to;
      clear_rom();
      rom[0]  = lui(5'd1, 20'h12345);
      rom[1]  = addi(5'd2, 5'd0, 12'hFFD);
      rom[2]  = addi(5'd3, 5'd0, 12'd7);
      rom[3]  = r_op(7'b0100000, 3'b000, 5'd4, 5'd2, 5'd3);
      rom[4]  = r_op(7'b0000000, 3'b110, 5'd5, 5'd1, 5'd3);
      rom[5]  = r_op(7'b0000000, 3'b100, 5'd6, 5'd2, 5'd3);
      rom[6]  = r_op(7'b0000000, 3'b111, 5'd7, 5'd2, 5'd3);
      rom[7]  = r_op(7'b0000000, 3'b010, 5'd8, 5'd2, 5'd3);
      rom[8]  = r_op(7'b0000000, 3'b010, 5'd9, 5'd3, 5'd2);
      rom[9]  = jal(5'd10, 21'd8);
      rom[10] = addi(5'd11, 5'd0, 12'd1);
      rom[11] = br(3'b000, 5'd3, 5'd3, 13'd8);
      rom[12] = addi(5'd12, 5'd0, 12'd1);
      rom[13] = br(3'b001, 5'd3, 5'd3, 13'd8);
      rom[14] = br(3'b101, 5'd2, 5'd3, 13'd8);
      rom[15] = br(3'b101, 5'd3, 5'd2, 13'd8);
      rom[16] = addi(5'd13, 5'd0, 12'd1);
      do_reset(); rstn = 1'b1;
      wait_done(400, to);
      checks++; if (to) begin failures++; $display("FAIL alu_timeout got=no_done exp=done"); end
      checks++; if (dut.u_regfile.regs[1] !== 32'h1234_5000) begin failures++; $display("FAIL alu_lui got=%h exp=12345000", dut.u_regfile.regs[1]); end
      checks++; if (dut.u_regfile.regs[4] !== 32'hFFFF_FFF6) begin failures++; $display("FAIL alu_sub got=%h exp=fffffff6", dut.u_regfile.regs[4]); end
      checks++; if (dut.u_regfile.regs[5] !== 32'h1234_5007) begin failures++; $display("FAIL alu_or got=%h exp=12345007", dut.u_regfile.regs[5]); end
      checks++; if (dut.u_regfile.regs[6] !== 32'hFFFF_FFFA) begin failures++; $display("FAIL alu_xor got=%h exp=fffffffa", dut.u_regfile.regs[6]); end
      checks++; if (dut.u_regfile.regs[7] !== 32'd5) begin failures++; $display("FAIL alu_and got=%h exp=5", dut.u_regfile.regs[7]); end
      checks++; if (dut.u_regfile.regs[8] !== 32'd1 || dut.u_regfile.regs[9] !== 32'd0) begin failures++; $display("FAIL alu_slt got=%0d/%0d exp=1/0", dut.u_regfile.regs[8], dut.u_regfile.regs[9]); end
      checks++; if (dut.u_regfile.regs[10] !== 32'd40) begin failures++; $display("FAIL alu_jal_link got=%0d exp=40", dut.u_regfile.regs[10]); end
      checks++; if ({dut.u_regfile.regs[11], dut.u_regfile.regs[12], dut.u_regfile.regs[13]} !== 96'd0) begin failures++; $display("FAIL alu_skipped got=%0d/%0d/%0d exp=0/0/0", dut.u_regfile.regs[11], dut.u_regfile.regs[12], dut.u_regfile.regs[13]); end
      checks++; if (instr_cnt !== 32'd14) begin failures++; $display("FAIL alu_instr_cnt got=%0d exp=14", instr_cnt); end
   endtask

   task automatic test_x0_illegal();
      bit to;
      clear_rom();
      rom[0] = addi(5'd5, 5'd0, 12'd3);
      rom[1] = addi(5'd0, 5'd0, 12'd9);
      rom[2] = r_op(7'b0000000, 3'b000, 5'd5, 5'd0, 5'd0);
      rom[3] = 32'h0000_007F;
      do_reset(); rstn = 1'b1;
      wait_done(200, to);
      checks++; if (to) begin failures++; $display("FAIL x0_timeout got=no_done exp=done"); end
      checks++; if (dut.u_regfile.regs[5] !== 32'd0 || dut.u_regfile.regs[0] !== 32'd0) begin failures++; $display("FAIL x0_zero got x5=%0d x0=%0d exp=0/0", dut.u_regfile.regs[5], dut.u_regfile.regs[0]); end
      checks++; if (illegal !== 1'b1 || done !== 1'b1) begin failures++; $display("FAIL x0_illegal got done=%b illegal=%b exp=1/1", done, illegal); end
      checks++; if (instr_cnt !== 32'd3 || clock_count !== 32'd14) begin failures++; $display("FAIL x0_counts got=%0d/%0d exp=3/14", instr_cnt, clock_count); end
   endtask

   task automatic test_reset_mid_mem();
      bit to;
      bit seen;
      int s0;
      clear_rom();
      rom[0] = addi(5'd1, 5'd0, 12'd5);
      rom[1] = sw(5'd1, 5'd0, 12'd4);
      dlat = 30;
      do_reset(); rstn = 1'b1;
      s0 = st_cnt;
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (dmem_req) begin seen = 1'b1; break; end
      end
      checks++; if (!seen) begin failures++; $display("FAIL midmem_reach got=no_dmem_req exp=dmem_req"); end
      checks++; if (instr_cnt !== 32'd1 || dmem_we !== 1'b1) begin failures++; $display("FAIL midmem_pre got cnt=%0d we=%b exp=1/1", instr_cnt, dmem_we); end
      rstn = 1'b0;
      @(posedge clk); #1;
      checks++; if (dmem_req !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL midmem_req got d=%b i=%b exp=0/0", dmem_req, imem_req); end
      checks++; if (imem_addr !== 10'd0 || clock_count !== 32'd0 || instr_cnt !== 32'd0) begin failures++; $display("FAIL midmem_state got pc=%0d cc=%0d ic=%0d exp=0/0/0", imem_addr, clock_count, instr_cnt); end
      @(negedge clk);
      dlat = 0;
      rstn = 1'b1;
      wait_done(200, to);
      checks++; if (to) begin failures++; $display("FAIL midmem_timeout got=no_done exp=done"); end
      checks++; if (st_cnt - s0 !== 1 || st_addr !== 32'd1 || st_data !== 32'd5) begin failures++; $display("FAIL midmem_restart_store got n=%0d addr=%0d data=%0d exp 1/1/5", st_cnt - s0, st_addr, st_data); end
      checks++; if (instr_cnt !== 32'd2 || illegal !== 1'b0) begin failures++; $display("FAIL midmem_restart_cnt got=%0d ill=%b exp=2/0", instr_cnt, illegal); end
   endtask

   task automatic test_mul();
      bit to;
      clear_rom();
      rom[0] = addi(5'd1, 5'd0, 12'hFFD);
      rom[1] = addi(5'd2, 5'd0, 12'd7);
      rom[2] = r_op(7'b0000001, 3'b000, 5'd6, 5'd1, 5'd2);
      do_reset(); rstn = 1'b1;
      wait_done(200, to);
      checks++; if (to) begin failures++; $display("FAIL mul_timeout got=no_done exp=done"); end
`ifdef RISCV_MC_MUL_EN
      checks++; if (dut.u_regfile.regs[6] !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_result got=%h exp=ffffffeb", dut.u_regfile.regs[6]); end
      checks++; if (illegal !== 1'b0 || instr_cnt !== 32'd3) begin failures++; $display("FAIL mul_status got ill=%b cnt=%0d exp=0/3", illegal, instr_cnt); end
`else
      checks++; if (illegal !== 1'b1 || dut.u_regfile.regs[6] !== 32'd0) begin failures++; $display("FAIL mul_illegal got ill=%b x6=%h exp=1/0", illegal, dut.u_regfile.regs[6]); end
      checks++; if (instr_cnt !== 32'd2) begin failures++; $display("FAIL mul_instr_cnt got=%0d exp=2", instr_cnt); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mem_wait();
      test_loop();
      test_alu_ops();
      test_x0_illegal();
      test_reset_mid_mem();
      test_mul();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/riscv_mc_core.md
Name: riscv_mc_core

Overview:
- Parametrised next-generation multicycle RV32 integer core.
- Instruction and data memories are external, behind variable-latency req/valid ports, so wait states, ROM or cache can sit behind them.
- Wider instruction subset, x0 hardwired to zero, illegal-instruction halt, cycle/retire counters.
- Top-level CPU of the multicycle build; memories and test harness instantiate around it.

Parameters:
- ADDR_W, 10, word-address width of both memory ports (byte address = word address << 2).
- PC_RESET, 32'h0000_0000, byte PC loaded on reset (must be 4-aligned).
- CNT_W, 32, width of clock_count and instr_cnt.

Ports:
- CLOCK_50  in  1  system clock.
- rstn  in  1  reset: synchronous, active-low; clock CLOCK_50.
- imem_req  out  1  instruction fetch request; held high until imem_valid.
- imem_addr  out  ADDR_W  fetch word address, PC[ADDR_W+1:2].
- imem_rdata  in  32  instruction word.
- imem_valid  in  1  imem_rdata valid; may assert in the same cycle as imem_req or any later cycle.
- dmem_req  out  1  data access request; held high until dmem_valid.
- dmem_we  out  1  1 = store, 0 = load; stable while dmem_req.
- dmem_addr  out  ADDR_W  data word address, (rs1 + imm)[ADDR_W+1:2].
- dmem_wdata  out  32  store data (rs2).
- dmem_rdata  in  32  load data.
- dmem_valid  in  1  load data valid / store accepted.
- done  out  1  program ended (EOF or illegal); sticky until reset.
- illegal  out  1  halted on an unsupported instruction; sticky.
- clock_count  out  CNT_W  cycles since reset; freezes when done rises.
- instr_cnt  out  CNT_W  retired instructions.

Behaviour:
- Reset (rstn low at a CLOCK_50 edge, any state):
  - state = IDLE, PC = PC_RESET.
  - All 32 registers, IR, MDR, ALUOut = 0.
  - done, illegal, clock_count, instr_cnt = 0.
  - imem_req, dmem_req deassert after that edge; an in-flight memory response is ignored.
- States:
  - IDLE -> IF unconditionally.
  - IF: imem_req = 1. On imem_valid, latch IR and go to ID.
  - ID: read rs1/rs2 into registers; ALUOut = PC + B/J offset.
    - IR == 32'hFFFF_FFFF -> HALT.
    - Unsupported opcode/funct -> HALT with illegal = 1.
    - Otherwise -> EX.
  - EX: ALU operation.
    - Branches: PC = taken ? ALUOut : PC+4, then IF.
    - jal: rd = PC+4, PC = ALUOut, then IF.
    - Loads/stores -> MEM; all others -> WB.
  - MEM: dmem_req = 1. On dmem_valid:
    - load: latch MDR, go to WB.
    - store: PC += 4, go to IF.
  - WB: rd = ALUOut or MDR; PC += 4; go to IF.
  - HALT: absorbing; done = 1; no requests.
- Supported instructions: add, sub, and, or, xor, slt (signed), addi, lw, sw, beq, bne, blt, bge (signed), jal, lui.
- Retire: instr_cnt increments by 1 in the cycle leaving EX (branch, jal), MEM (store) or WB.
- Latency with zero-wait memory (imem_valid combinational):
  - branch/jal: 3 cycles.
  - ALU/lui/store: 4 cycles.
  - load: 5 cycles.
  - Each memory wait cycle adds 1.
- Arithmetic: 32-bit, wrap-around, no overflow flag.
  - Immediates are sign-extended.
  - lui = {imm[31:12], 12'b0}.
- Register writes to x0 are discarded; x0 always reads 0. rd == rs1 is legal (read in ID precedes write).
- Address wrap: addresses are truncated to ADDR_W; misaligned low bits are ignored.
- PC wraps modulo 2^32.
- clock_count saturates at all-ones; instr_cnt wraps.

Optional Feature:
- Macro RISCV_MC_MUL_EN.
- Defined: funct7 = 0000001, funct3 = 000 on opcode 0110011 executes mul (low 32 bits of the product, EX single cycle).
- Undefined: that encoding is illegal (HALT, illegal = 1).

Decomposition:
- Package riscv_pkg:
  - opcode localparams (R, I-ALU, LOAD, STORE, BRANCH, JAL, LUI);
  - funct3/funct7 codes;
  - state encoding (IDLE, IF, ID, EX, MEM, WB, HALT);
  - EOF constant 32'hFFFF_FFFF.
- Sub-module riscv_regfile:
  - 32x32 registers, 2 async read ports, 1 sync write port;
  - x0 forced to zero;
  - reset clears all registers.

Test Plan:
- Program addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; EOF with zero-wait memories -> x3 = 12, instr_cnt = 3, done = 1 at cycle 14, clock_count frozen at 14.
- sw x3,8(x0) then lw x4,8(x0) with dmem_valid delayed 3 cycles -> dmem_addr = 2, dmem_wdata = 12, x4 = 12, each access 3 cycles longer.
- Loop: x1 = 0, x2 = 4, body addi x1,x1,1; blt x1,x2,-4 -> branch taken 3 times; x1 = 4; instr_cnt = 2 + 8.
- addi x0,x0,9 then add x5,x0,x0 -> x5 = 0. Opcode 7'b1111111 with nonzero bits -> done = 1, illegal = 1.
- Assert rstn low while in MEM with dmem_req high -> next cycle dmem_req = 0, PC = PC_RESET, all counters 0; execution restarts cleanly.
- mul x6,x1,x2 with x1 = -3, x2 = 7 -> x6 = 32'hFFFF_FFEB when RISCV_MC_MUL_EN is defined; illegal = 1 when it is not.
